fetch_prefetch: RTL and testbench
=================================

// Module: fetch_prefetch
// PURPOSE
//  Successor to the single-register fetch stage: an IF stage with a QDEPTH-entry prefetch queue.
//  Instruction fetch runs ahead of decode, so instruction-memory hits can be absorbed while decode stalls.
//  Sits between the I-side of datapath_cache_if and fetch_decode_if. Redirects flush all wrong-path state.
// PARAMETERS
//  PC_INIT   0   PC value loaded at reset
//  QDEPTH    4   prefetch queue entries; power of two, >= 2
// PORTS
//  CLK           in   1     clock
//  nRST          in   1     reset, synchronous, active-low
//  en            in   1     decode may accept a new instruction this cycle
//  bubble        in   1     load a NOP into the output register without popping the queue
//  redirect_en   in   1     later stage redirects fetch (branch/jump/mispredict)
//  redirect_pc   in   32    redirect target (word_t)
//  ihit          in   1     imemload valid for imemaddr this cycle
//  halt          in   1     stop fetching; hold the output
//  imemload      in   32    fetched instruction
//  branch_taken  in   1     predictor result for imemaddr; sampled with ihit
//  imemREN       out  1     instruction read enable
//  imemaddr      out  32    fetch PC
//  npc_valid     out  1     an entry is pushed this cycle
//  npc_default   out  32    imemaddr + 4
//  q_count       out  $clog2(QDEPTH)+1  current queue occupancy
//  out           fetch_decode_if.fetch  instruction, instr_npc, branch_taken (registered)
// BEHAVIOUR
//  Reset (nRST low at posedge): fpc<=PC_INIT; queue empty; q_count=0; out.* <= 0.
//  imemREN = !halt && (q_count != QDEPTH); imemaddr = fpc; npc_default = fpc + 4 (mod 2^32).
//  push = ihit && imemREN && !redirect_en; npc_valid = push.
//  Pushed entry = {imemload, npc_default, branch_taken}.
//  fpc update: redirect_en -> redirect_pc, regardless of ihit/halt; else push -> npc_default; else hold.
//  advance = en && !halt. When !advance, out.* holds its value.
//  When advance, in priority order:
//   1. redirect_en -> out <= 0; no pop.
//   2. bubble -> out <= 0; no pop.
//   3. q_count > 0 -> out <= queue head; pop.
//   4. push (queue empty) -> out <= incoming entry (bypass); the entry is not also enqueued.
//   5. otherwise -> out <= 0.
//  redirect_en: queue flushed to empty the same cycle; discards any concurrent push/pop.
//  Push and pop in the same cycle: q_count unchanged. Pointers wrap modulo QDEPTH.
//  Full: imemREN=0, so no push, even if a pop occurs that cycle (no en->imemREN combinational path).
//  Latency: ihit at cycle t with an empty queue and advance -> out valid after edge t+1.
//  halt: no fetch, no pop, out held; a redirect during halt still updates fpc and flushes the queue.
//  Reset mid-operation discards all entries; nothing is ever popped from an empty queue.
// STRUCTURE
//  cpu_types_pkg additions:
//   typedef struct packed {word_t instruction; word_t instr_npc; logic branch_taken;} fetch_entry_t;
//   localparam word_t NOP_INSTR = '0.
//  Sub-module fetch_fifo:
//   generic sync FIFO of fetch_entry_t; params DEPTH; ports push, pop, flush, full, empty, count.
//   flush has priority over push and pop.
//  Top level holds fpc, the output register and the priority mux.
// TESTING
//  1 Reset then en=1, ihit=1 every cycle, imemload=0x1000+n:
//    imemaddr 0,4,8..; out.instruction 0x1000,0x1001.. one cycle behind; instr_npc = addr+4.
//  2 en=0 with ihit=1 for 6 cycles, QDEPTH=4:
//    q_count 1..4 then stays 4; imemREN=0 at 4; imemaddr stops at 0x10.
//    en=1 -> 4 pops in order, then refill.
//  3 Queue holds 3 entries; redirect_en=1, redirect_pc=0x200 with en=1:
//    q_count->0, out=0; next imemaddr=0x200; first valid out is the instruction at 0x200.
//  4 Push and pop in the same cycle with q_count=2 -> q_count stays 2; order preserved across pointer wrap.
//  5 halt=1 with 2 queued -> imemREN=0, out held, q_count 2.
//    redirect during halt -> q_count 0, fpc=target.
//  6 bubble=1 with q_count=1 -> out=0, q_count stays 1.
//    nRST low mid-stream -> all outputs zero and fpc=PC_INIT next edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch queue entry and the NOP encoding.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instruction;
        word_t instr_npc;
        logic  branch_taken;
    } fetch_entry_t;

    localparam word_t NOP_INSTR = '0;
endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it and overrides push/pop.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/fetch_prefetch.sv
// IF stage with a prefetch queue: fetch runs ahead of decode, redirects flush wrong-path state.
module fetch_prefetch
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT = '0,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    en,
    input  logic                    bubble,
    input  logic                    redirect_en,
    input  logic [31:0]             redirect_pc,
    input  logic                    ihit,
    input  logic                    halt,
    input  logic [31:0]             imemload,
    input  logic                    branch_taken,
    output logic                    imemREN,
    output logic [31:0]             imemaddr,
    output logic                    npc_valid,
    output logic [31:0]             npc_default,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic [31:0]             out_instruction,
    output logic [31:0]             out_instr_npc,
    output logic                    out_branch_taken
);
    word_t        fpc;
    fetch_entry_t incoming, head;
    logic         q_full, q_empty;
    logic         push, advance, take_head, bypass;

    assign imemREN     = !halt && !q_full;
    assign imemaddr    = fpc;
    assign npc_default = fpc + 32'd4;
    assign push        = ihit && imemREN && !redirect_en;
    assign npc_valid   = push;
    assign advance     = en && !halt;
    assign incoming    = '{instruction: imemload, instr_npc: npc_default, branch_taken: branch_taken};

    // A push into an empty queue that decode consumes right away skips the queue.
    assign take_head = advance && !redirect_en && !bubble && !q_empty;
    assign bypass    = advance && !bubble && q_empty && push;

    fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push && !bypass),
        .pop   (take_head),
        .flush (redirect_en),
        .din   (incoming),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            fpc <= PC_INIT;
        end else if (redirect_en) begin
            fpc <= redirect_pc;
        end else if (push) begin
            fpc <= npc_default;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_instruction  <= NOP_INSTR;
            out_instr_npc    <= '0;
            out_branch_taken <= 1'b0;
        end else if (advance) begin
            if (take_head) begin
                out_instruction  <= head.instruction;
                out_instr_npc    <= head.instr_npc;
                out_branch_taken <= head.branch_taken;
            end else if (bypass) begin
                out_instruction  <= incoming.instruction;
                out_instr_npc    <= incoming.instr_npc;
                out_branch_taken <= incoming.branch_taken;
            end else begin
                out_instruction  <= NOP_INSTR;
                out_instr_npc    <= '0;
                out_branch_taken <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed and short random bench for fetch_prefetch against a queue-based reference model.
module tb_fetch_prefetch;
    localparam int unsigned QDEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST, en, bubble, redirect_en, ihit, halt, branch_taken;
    logic [31:0] redirect_pc, imemload;
    logic        imemREN, npc_valid, out_branch_taken;
    logic [31:0] imemaddr, npc_default, out_instruction, out_instr_npc;
    logic [2:0]  q_count;

    fetch_prefetch #(.PC_INIT(32'h0), .QDEPTH(QDEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .bubble(bubble),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .ihit(ihit), .halt(halt), .imemload(imemload), .branch_taken(branch_taken),
        .imemREN(imemREN), .imemaddr(imemaddr), .npc_valid(npc_valid),
        .npc_default(npc_default), .q_count(q_count),
        .out_instruction(out_instruction), .out_instr_npc(out_instr_npc),
        .out_branch_taken(out_branch_taken)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] npc;
        logic        bt;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    bit          m_valid = 0;
    logic [31:0] m_fpc = '0;
    ent_t        m_q[$];
    logic [31:0] m_ins = '0, m_npc = '0;
    logic        m_bt = 1'b0;
    logic [31:0] saved_ins;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        bit ren, push;
        if (!m_valid) return;
        ren  = !halt && (m_q.size() != QDEPTH);
        push = ihit && ren && !redirect_en;
        chk("imemREN", 32'(imemREN), 32'(ren));
        chk("imemaddr", imemaddr, m_fpc);
        chk("npc_default", npc_default, m_fpc + 32'd4);
        chk("npc_valid", 32'(npc_valid), 32'(push));
        chk("q_count", 32'(q_count), 32'(m_q.size()));
        chk("out_instruction", out_instruction, m_ins);
        chk("out_instr_npc", out_instr_npc, m_npc);
        chk("out_branch_taken", 32'(out_branch_taken), 32'(m_bt));
    endtask

    task automatic model_update();
        bit   ren, push;
        ent_t inc;
        if (!nRST) begin
            m_fpc = '0;
            m_q.delete();
            m_ins = '0; m_npc = '0; m_bt = 1'b0;
            m_valid = 1;
            return;
        end
        ren  = !halt && (m_q.size() != QDEPTH);
        push = ihit && ren && !redirect_en;
        inc  = '{imemload, m_fpc + 32'd4, branch_taken};
        if (en && !halt) begin
            if (redirect_en || bubble) begin
                m_ins = '0; m_npc = '0; m_bt = 1'b0;
            end else if (m_q.size() > 0) begin
                ent_t h;
                h = m_q.pop_front();
                m_ins = h.ins; m_npc = h.npc; m_bt = h.bt;
            end else if (push) begin
                m_ins = inc.ins; m_npc = inc.npc; m_bt = inc.bt;
                m_fpc = m_fpc + 32'd4;
                push  = 0;
                ren   = 0;
            end else begin
                m_ins = '0; m_npc = '0; m_bt = 1'b0;
            end
        end
        if (redirect_en) begin
            m_q.delete();
            m_fpc = redirect_pc;
        end else if (push) begin
            m_q.push_back(inc);
            m_fpc = m_fpc + 32'd4;
        end
    endtask

    // Memory returns 0x1000 + word index of the model's fetch PC.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            imemload     = 32'h1000 + (m_fpc >> 2);
            branch_taken = m_fpc[2];
            #1;
            check_all();
            model_update();
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic set_in(input logic n, input logic e, input logic h, input logic b,
                          input logic r, input logic [31:0] rpc, input logic hl);
        nRST = n; en = e; ihit = h; bubble = b; redirect_en = r; redirect_pc = rpc; halt = hl;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 32'h0, 0);
        imemload = '0; branch_taken = 1'b0;
        @(negedge CLK);
        step(2);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_imemaddr", imemaddr, 32'h0);
        chk("rst_out", out_instruction, 32'h0);

        // Streaming with decode always ready.
        set_in(1, 1, 1, 0, 0, 32'h0, 0);
        step(2);
        chk("t1_out", out_instruction, 32'h1001);
        chk("t1_npc", out_instr_npc, 32'h8);
        chk("t1_addr", imemaddr, 32'h8);
        step(2);

        // Fill to full with decode stalled, then drain in order.
        set_in(0, 0, 0, 0, 0, 32'h0, 0);
        step(1);
        set_in(1, 0, 1, 0, 0, 32'h0, 0);
        step(6);
        chk("t2_full_count", 32'(q_count), 32'd4);
        chk("t2_full_addr", imemaddr, 32'h10);
        chk("t2_full_ren", 32'(imemREN), 32'd0);
        set_in(1, 1, 0, 0, 0, 32'h0, 0);
        step(1);
        chk("t2_pop0", out_instruction, 32'h1000);
        chk("t2_pop0_cnt", 32'(q_count), 32'd3);
        step(3);
        chk("t2_pop3", out_instruction, 32'h1003);
        chk("t2_empty", 32'(q_count), 32'd0);
        set_in(1, 1, 1, 0, 0, 32'h0, 0);
        step(2);
        chk("t2_refill", out_instruction, 32'h1005);

        // Redirect flushes a partly full queue.
        set_in(1, 0, 1, 0, 0, 32'h0, 0);
        step(3);
        set_in(1, 1, 1, 0, 1, 32'h200, 0);
        step(1);
        chk("t3_cnt", 32'(q_count), 32'd0);
        chk("t3_out", out_instruction, 32'h0);
        chk("t3_addr", imemaddr, 32'h200);
        set_in(1, 1, 1, 0, 0, 32'h0, 0);
        step(1);
        chk("t3_first", out_instruction, 32'h1080);
        chk("t3_first_npc", out_instr_npc, 32'h204);

        // Simultaneous push and pop across pointer wrap.
        set_in(1, 0, 1, 0, 0, 32'h0, 0);
        step(2);
        set_in(1, 1, 1, 0, 0, 32'h0, 0);
        step(6);
        chk("t4_cnt", 32'(q_count), 32'd2);

        // Halt holds everything; redirect during halt still flushes.
        saved_ins = m_ins;
        set_in(1, 1, 1, 0, 0, 32'h0, 1);
        step(2);
        chk("t5_ren", 32'(imemREN), 32'd0);
        chk("t5_cnt", 32'(q_count), 32'd2);
        chk("t5_hold", out_instruction, saved_ins);
        set_in(1, 1, 1, 0, 1, 32'h300, 1);
        step(1);
        chk("t5_redir_cnt", 32'(q_count), 32'd0);
        chk("t5_redir_addr", imemaddr, 32'h300);
        chk("t5_redir_hold", out_instruction, saved_ins);

        // Bubble inserts a NOP without popping; reset mid-stream clears all.
        set_in(1, 0, 1, 0, 0, 32'h0, 0);
        step(1);
        set_in(1, 1, 0, 1, 0, 32'h0, 0);
        step(1);
        chk("t6_bubble_out", out_instruction, 32'h0);
        chk("t6_bubble_cnt", 32'(q_count), 32'd1);
        set_in(1, 1, 0, 0, 0, 32'h0, 0);
        step(1);
        chk("t6_pop", out_instruction, 32'h10C0);
        chk("t6_pop_npc", out_instr_npc, 32'h304);
        set_in(1, 0, 1, 0, 0, 32'h0, 0);
        step(2);
        set_in(0, 0, 0, 0, 0, 32'h0, 0);
        step(1);
        chk("t6_rst_addr", imemaddr, 32'h0);
        chk("t6_rst_cnt", 32'(q_count), 32'd0);
        chk("t6_rst_out", out_instruction, 32'h0);
        chk("t6_rst_npc", out_instr_npc, 32'h0);

        // Mixed traffic checked against the model every cycle.
        for (int i = 0; i < 60; i++) begin
            set_in(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                   32'($urandom_range(0, 255)) << 2, $urandom_range(0, 9) == 0);
            step(1);
        end
        set_in(1, 0, 0, 0, 0, 32'h0, 0);
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
